alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Driver-and-collector end of the 32-bit ALU interface.
- Accepts operation requests over a valid/ready handshake and registers the operands and the 2-bit control onto the ALU input busses.
- Captures the ALU result and flags one cycle later, evaluates RISC-V branch conditions from the flags, and presents results on a backpressurable output.
- Sits between decode/register-read and writeback/branch resolution; the ALU itself stays external and combinational.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU datapath.
- TAG_W, 5, width of the opaque tag (destination register index) carried alongside each operation.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  stage can accept a request this cycle.
- in_op  input  4  operation code (see Behaviour).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_tag  input  TAG_W  opaque tag.
- alu_a  output  WIDTH  to ALU BussA.
- alu_b  output  WIDTH  to ALU BussB.
- alu_ctl  output  2  to ALU control: bit1 = subtract/SLT path, bit0 = XOR/SLT select.
- alu_result  input  WIDTH  from ALU Output.
- alu_carry  input  1  from ALU CarryOut; during subtract it is the borrow (1 when A < B unsigned).
- alu_zero  input  1  from ALU zero.
- alu_ovf  input  1  from ALU overflow.
- alu_neg  input  1  from ALU negative.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_result  output  WIDTH  captured ALU result; 0 for branches and illegal ops.
- out_flags  output  4  {carry, overflow, negative, zero} captured from the ALU.
- out_is_branch  output  1  operation was a branch.
- out_taken  output  1  branch condition true.
- out_illegal  output  1  op code unsupported.
- out_tag  output  TAG_W  tag of the operation.

Behaviour:
- Op codes and alu_ctl:
  - 0 ADD → 00; 1 SUB → 10; 2 XOR → 01; 3 SLT → 11.
  - Branches all drive alu_ctl = 10 (subtract): 8 BEQ, 9 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
  - All other codes are illegal: alu_ctl = 00 and out_illegal = 1.
- Branch evaluation, from the flags captured for that op:
  - BEQ = zero; BNE = !zero.
  - BLT = neg ^ ovf; BGE = !(neg ^ ovf).
  - BLTU = carry; BGEU = !carry.
  - Non-branch ops: out_taken = 0, out_is_branch = 0.
- Pipeline is two register stages, S1 (issue) and S2 (collect), each with a valid bit.
  - S1 holds op, tag, a, b; alu_a, alu_b and alu_ctl are driven directly from the S1 registers.
  - S2 holds result, flags, branch/taken/illegal and tag; all out_* come directly from S2 registers (no combinational path from the alu_* inputs to the outputs).
- Advance rules:
  - s2_free = !s2_valid || out_ready.
  - S1 → S2 transfer occurs when s1_valid && s2_free; S2 captures the alu_* inputs at that edge.
  - in_ready = !s1_valid || s2_free (combinational from out_ready; no combinational in_valid → in_ready path).
  - S1 loads when in_valid && in_ready.
  - If S2 drains with no S1 transfer, s2_valid clears.
- Latency and throughput:
  - Request accepted at edge k → out_valid high after edge k+1.
  - Sustained throughput is 1 op/cycle while out_ready stays high.
- Stall:
  - While out_valid && !out_ready, all out_* hold stable.
  - S1 and the alu_* outputs hold stable; the ALU output is re-sampled only on the transfer edge.
  - With both stages full, in_ready = 0.
- Simultaneous events: accept, S1→S2 transfer and S2 drain in the same cycle are all legal; no bubble is inserted.
- Reset (asynchronous, any time including mid-stall):
  - s1_valid = s2_valid = 0, so in_ready = 1 and out_valid = 0.
  - alu_a = alu_b = 0, alu_ctl = 00.
  - out_result = 0, out_flags = 0, out_tag = 0, out_is_branch = out_taken = out_illegal = 0.
  - In-flight ops are discarded.
- Width rules:
  - out_result for SLT is the ALU value as given (0 or 1 in bit 0).
  - The block never modifies the ALU result for ADD/SUB/XOR/SLT.

Test Plan:
- ADD a=0x7FFFFFFF, b=1, tag=3, out_ready=1 → alu_ctl=00 one cycle after accept; out_valid the next cycle; result 0x80000000, flags ovf=1, neg=1, zero=0, carry=0, tag=3.
- Back-to-back SUB 5−5, XOR 0xF0F0F0F0^0xFFFFFFFF, SLT −1<1, over 3 cycles → outputs on consecutive cycles: {0, zero=1}, {0x0F0F0F0F}, {1}; in_ready stays 1.
- BLTU a=1, b=0xFFFFFFFF and BLT with the same operands → BLTU taken=1; BLT taken=0; out_result=0; out_is_branch=1.
- Backpressure: hold out_ready=0 for 4 cycles while 3 requests are offered → only 2 accepted; in_ready=0 afterwards; out_* and alu_* stable. Release → ops emerge in order, one per cycle.
- Illegal op 5 → out_illegal=1, alu_ctl=00, out_taken=0, out_result=0.
- Assert reset mid-stall with both stages full → out_valid=0 and in_ready=1 immediately (asynchronously); all outputs 0; the first op after reset returns correctly at latency 2.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Two-stage issue/collect wrapper around an external combinational 32-bit ALU.
// S1 drives the ALU input busses; S2 captures the ALU response and resolves branches.
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    input  logic             alu_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_is_branch,
    output logic             out_taken,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_BNE  = 4'd9;
    localparam logic [3:0] OP_BLT  = 4'd12;
    localparam logic [3:0] OP_BGE  = 4'd13;
    localparam logic [3:0] OP_BLTU = 4'd14;
    localparam logic [3:0] OP_BGEU = 4'd15;

    // Stage 1 (issue)
    logic             s1_valid_reg;
    logic [3:0]       s1_op_reg;
    logic [1:0]       s1_ctl_reg;
    logic             s1_branch_reg;
    logic             s1_illegal_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    // Stage 2 (collect)
    logic             s2_valid_reg;
    logic [WIDTH-1:0] s2_result_reg;
    logic [3:0]       s2_flags_reg;
    logic             s2_branch_reg;
    logic             s2_taken_reg;
    logic             s2_illegal_reg;
    logic [TAG_W-1:0] s2_tag_reg;

    logic             s2_free;
    logic             s1_xfer;
    logic             s1_load;

    logic [1:0]       dec_ctl;
    logic             dec_branch;
    logic             dec_illegal;

    logic             taken_next;
    logic             keep_result;
    logic [WIDTH-1:0] result_next;

    assign s2_free  = !s2_valid_reg || out_ready;
    assign s1_xfer  = s1_valid_reg && s2_free;
    assign in_ready = !s1_valid_reg || s2_free;
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        dec_ctl     = 2'b00;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        case (in_op)
            OP_ADD: dec_ctl = 2'b00;
            OP_SUB: dec_ctl = 2'b10;
            OP_XOR: dec_ctl = 2'b01;
            OP_SLT: dec_ctl = 2'b11;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                dec_ctl    = 2'b10;
                dec_branch = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Branch conditions use the subtract flags; carry is the unsigned borrow.
    always_comb begin
        taken_next = 1'b0;
        case (s1_op_reg)
            OP_BEQ:  taken_next = alu_zero;
            OP_BNE:  taken_next = !alu_zero;
            OP_BLT:  taken_next = alu_neg ^ alu_ovf;
            OP_BGE:  taken_next = !(alu_neg ^ alu_ovf);
            OP_BLTU: taken_next = alu_carry;
            OP_BGEU: taken_next = !alu_carry;
            default: taken_next = 1'b0;
        endcase
    end

    assign keep_result = !s1_branch_reg && !s1_illegal_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_result_mask
            assign result_next[gi] = alu_result[gi] & keep_result;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg   <= 1'b0;
            s1_op_reg      <= 4'd0;
            s1_ctl_reg     <= 2'b00;
            s1_branch_reg  <= 1'b0;
            s1_illegal_reg <= 1'b0;
            s1_a_reg       <= '0;
            s1_b_reg       <= '0;
            s1_tag_reg     <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_reg   <= 1'b1;
                s1_op_reg      <= in_op;
                s1_ctl_reg     <= dec_ctl;
                s1_branch_reg  <= dec_branch;
                s1_illegal_reg <= dec_illegal;
                s1_a_reg       <= in_a;
                s1_b_reg       <= in_b;
                s1_tag_reg     <= in_tag;
            end else if (s1_xfer) begin
                s1_valid_reg   <= 1'b0;
            end
        end
    end

    // ALU response is sampled only on the transfer edge, so a stall holds S2 untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_reg   <= 1'b0;
            s2_result_reg  <= '0;
            s2_flags_reg   <= 4'd0;
            s2_branch_reg  <= 1'b0;
            s2_taken_reg   <= 1'b0;
            s2_illegal_reg <= 1'b0;
            s2_tag_reg     <= '0;
        end else begin
            if (s1_xfer) begin
                s2_valid_reg   <= 1'b1;
                s2_result_reg  <= result_next;
                s2_flags_reg   <= {alu_carry, alu_ovf, alu_neg, alu_zero};
                s2_branch_reg  <= s1_branch_reg;
                s2_taken_reg   <= s1_branch_reg && taken_next;
                s2_illegal_reg <= s1_illegal_reg;
                s2_tag_reg     <= s1_tag_reg;
            end else if (s2_free) begin
                s2_valid_reg   <= 1'b0;
            end
        end
    end

    assign alu_a         = s1_a_reg;
    assign alu_b         = s1_b_reg;
    assign alu_ctl       = s1_ctl_reg;

    assign out_valid     = s2_valid_reg;
    assign out_result    = s2_result_reg;
    assign out_flags     = s2_flags_reg;
    assign out_is_branch = s2_branch_reg;
    assign out_taken     = s2_taken_reg;
    assign out_illegal   = s2_illegal_reg;
    assign out_tag       = s2_tag_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a bit-level ALU answers the DUT, and an arithmetic
// reference model predicts every collected result.
module tb_alu_issue_stage;
    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic             clk, reset;
    logic             in_valid, in_ready;
    logic [3:0]       in_op;
    logic [31:0]      in_a, in_b;
    logic [4:0]       in_tag;
    logic [31:0]      alu_a, alu_b, alu_result;
    logic [1:0]       alu_ctl;
    logic             alu_carry, alu_zero, alu_ovf, alu_neg;
    logic             out_valid, out_ready;
    logic [31:0]      out_result;
    logic [3:0]       out_flags;
    logic             out_is_branch, out_taken, out_illegal;
    logic [4:0]       out_tag;

    alu_issue_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_ovf(alu_ovf), .alu_neg(alu_neg),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_is_branch(out_is_branch), .out_taken(out_taken),
        .out_illegal(out_illegal), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: ripple-style 33-bit add/sub with sign-bit overflow detection
    logic [32:0] add33, sub33;
    logic        add_v, sub_v;
    always_comb begin
        add33 = {1'b0, alu_a} + {1'b0, alu_b};
        sub33 = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        add_v = (alu_a[31] == alu_b[31]) && (add33[31] != alu_a[31]);
        sub_v = (alu_a[31] != alu_b[31]) && (sub33[31] != alu_a[31]);
        alu_result = add33[31:0];
        alu_carry  = add33[32];
        alu_ovf    = add_v;
        case (alu_ctl)
            2'b10: begin alu_result = sub33[31:0]; alu_carry = ~sub33[32]; alu_ovf = sub_v; end
            2'b01: begin alu_result = alu_a ^ alu_b; alu_carry = 1'b0; alu_ovf = 1'b0; end
            2'b11: begin alu_result = {31'd0, sub33[31] ^ sub_v}; alu_carry = ~sub33[32]; alu_ovf = sub_v; end
            default: ;
        endcase
        alu_neg  = alu_result[31];
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        br;
        logic        tk;
        logic        ill;
        logic [4:0]  tag;
    } out_t;

    typedef struct packed {
        logic        in_rdy;
        logic        ov;
        out_t        o;
        logic [31:0] aa;
        logic [31:0] ab;
        logic [1:0]  ctl;
    } snap_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference: plain integer arithmetic on the operands, independent of flag tricks
    function automatic out_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] tag);
        out_t        r;
        longint      sa, sb, s_sum, s_dif;
        logic [63:0] u_sum;
        logic [31:0] val;
        logic        c, v, lt_s, lt_u, br, alu_op;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        s_sum = sa + sb;
        s_dif = sa - sb;
        u_sum = {32'd0, a} + {32'd0, b};
        lt_s  = sa < sb;
        lt_u  = a < b;
        br     = op inside {4'd8, 4'd9, 4'd12, 4'd13, 4'd14, 4'd15};
        alu_op = op <= 4'd3;
        if (op == 4'd2) begin
            val = a ^ b; c = 1'b0; v = 1'b0;
        end else if (op == 4'd3) begin
            val = lt_s ? 32'd1 : 32'd0; c = lt_u; v = (s_dif > SMAX) || (s_dif < SMIN);
        end else if (op == 4'd1 || br) begin
            val = a - b; c = lt_u; v = (s_dif > SMAX) || (s_dif < SMIN);
        end else begin
            val = a + b; c = u_sum[32]; v = (s_sum > SMAX) || (s_sum < SMIN);
        end
        r.flags  = {c, v, val[31], val == 32'd0};
        r.result = alu_op ? val : 32'd0;
        r.br     = br;
        r.ill    = !(alu_op || br);
        case (op)
            4'd8:    r.tk = (a == b);
            4'd9:    r.tk = (a != b);
            4'd12:   r.tk = lt_s;
            4'd13:   r.tk = !lt_s;
            4'd14:   r.tk = lt_u;
            4'd15:   r.tk = !lt_u;
            default: r.tk = 1'b0;
        endcase
        r.tag = tag;
        return r;
    endfunction

    // One clock: drive at posedge+1, sample at negedge, return at next posedge+1
    task automatic cycle(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic rdy, output snap_t s);
        in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = rdy;
        @(negedge clk);
        s.in_rdy   = in_ready;
        s.ov       = out_valid;
        s.o.result = out_result;
        s.o.flags  = out_flags;
        s.o.br     = out_is_branch;
        s.o.tk     = out_taken;
        s.o.ill    = out_illegal;
        s.o.tag    = out_tag;
        s.aa       = alu_a;
        s.ab       = alu_b;
        s.ctl      = alu_ctl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        snap_t s;
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, s);
        vectors++;
        if (s.in_rdy !== 1'b1 || s.ov !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", s.in_rdy, s.ov);
        end
        vectors++;
        if (s.o !== '0 || s.aa !== 32'd0 || s.ab !== 32'd0 || s.ctl !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_vals: out=%h alu=%h/%h/%b want all 0", s.o, s.aa, s.ab, s.ctl);
        end
    endtask

    task automatic test_add();
        snap_t s;
        out_t  e;
        e.result = 32'h8000_0000; e.flags = 4'b0110; e.br = 0; e.tk = 0; e.ill = 0; e.tag = 5'd3;
        cycle(1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1, s);
        vectors++;
        if (s.in_rdy !== 1'b1) begin
            miscompares++; $display("FAIL add_accept: in_ready=%b want 1", s.in_rdy);
        end
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, s);
        vectors++;
        if (s.ctl !== 2'b00 || s.aa !== 32'h7FFF_FFFF || s.ab !== 32'd1 || s.ov !== 1'b0) begin
            miscompares++;
            $display("FAIL add_issue: ctl=%b a=%h b=%h ov=%b want 00 7fffffff 00000001 0", s.ctl, s.aa, s.ab, s.ov);
        end
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, s);
        vectors++;
        if (s.ov !== 1'b1 || s.o !== e) begin
            miscompares++; $display("FAIL add_result: ov=%b out=%h want 1 %h", s.ov, s.o, e);
        end
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, s);
        vectors++;
        if (s.ov !== 1'b0) begin
            miscompares++; $display("FAIL add_drain: out_valid=%b want 0", s.ov);
        end
    endtask

    task automatic test_back_to_back();
        snap_t       s;
        out_t        e;
        logic [3:0]  ops [3];
        logic [31:0] as  [3];
        logic [31:0] bs  [3];
        logic [31:0] res [3];
        ops = '{4'd1, 4'd2, 4'd3};
        as  = '{32'd5, 32'hF0F0_F0F0, 32'hFFFF_FFFF};
        bs  = '{32'd5, 32'hFFFF_FFFF, 32'd1};
        res = '{32'd0, 32'h0F0F_0F0F, 32'd1};
        for (int i = 0; i < 6; i++) begin
            if (i < 3) cycle(1'b1, ops[i], as[i], bs[i], 5'(10 + i), 1'b1, s);
            else       cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, s);
            if (i < 3) begin
                vectors++;
                if (s.in_rdy !== 1'b1) begin
                    miscompares++; $display("FAIL b2b_ready[%0d]: in_ready=%b want 1", i, s.in_rdy);
                end
            end
            if (i >= 2 && i < 5) begin
                e = model(ops[i-2], as[i-2], bs[i-2], 5'(8 + i));
                vectors++;
                if (s.ov !== 1'b1 || s.o !== e || s.o.result !== res[i-2]) begin
                    miscompares++;
                    $display("FAIL b2b_out[%0d]: ov=%b out=%h want 1 %h", i - 2, s.ov, s.o, e);
                end
            end
        end
        vectors++;
        if (s.o.flags !== 4'b0000 || s.ov !== 1'b0) begin
            miscompares++; $display("FAIL b2b_tail: flags=%b ov=%b want 0000 0", s.o.flags, s.ov);
        end
    endtask

    task automatic test_branch();
        snap_t      s;
        out_t       e;
        logic [3:0] ops [2];
        logic       tk  [2];
        ops = '{4'd14, 4'd12};
        tk  = '{1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i < 2) cycle(1'b1, ops[i], 32'd1, 32'hFFFF_FFFF, 5'(20 + i), 1'b1, s);
            else       cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, s);
            if (i >= 2) begin
                e = model(ops[i-2], 32'd1, 32'hFFFF_FFFF, 5'(18 + i));
                vectors++;
                if (s.ov !== 1'b1 || s.o.tk !== tk[i-2] || s.o.br !== 1'b1 || s.o.result !== 32'd0 || s.o !== e) begin
                    miscompares++;
                    $display("FAIL branch[%0d]: ov=%b out=%h want 1 %h", i - 2, s.ov, s.o, e);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        snap_t       s, held;
        out_t        e;
        logic [3:0]  ops [3];
        logic [31:0] as  [3];
        logic [31:0] bs  [3];
        for (int k = 0; k < 3; k++) begin
            ops[k] = 4'($urandom_range(0, 3));
            as[k]  = $urandom;
            bs[k]  = $urandom;
        end
        held = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < 2)      cycle(1'b1, ops[j], as[j], bs[j], 5'(j), 1'b0, s);
            else if (j < 4) cycle(1'b1, ops[2], as[2], bs[2], 5'd2, 1'b0, s);
            else if (j == 4) cycle(1'b1, ops[2], as[2], bs[2], 5'd2, 1'b1, s);
            else            cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, s);
            if (j < 2 || j == 4) begin
                vectors++;
                if (s.in_rdy !== 1'b1) begin
                    miscompares++; $display("FAIL bp_accept[%0d]: in_ready=%b want 1", j, s.in_rdy);
                end
            end
            if (j == 2) begin
                held = s;
                e = model(ops[0], as[0], bs[0], 5'd0);
                vectors++;
                if (s.in_rdy !== 1'b0 || s.ov !== 1'b1 || s.o !== e || s.aa !== as[1] || s.ab !== bs[1]) begin
                    miscompares++;
                    $display("FAIL bp_full: in_ready=%b ov=%b out=%h alu_a=%h want 0 1 %h %h", s.in_rdy, s.ov, s.o, s.aa, e, as[1]);
                end
            end
            if (j == 3) begin
                vectors++;
                if (s.in_rdy !== 1'b0 || s.ov !== 1'b1 || s.o !== held.o || s.aa !== held.aa || s.ab !== held.ab || s.ctl !== held.ctl) begin
                    miscompares++;
                    $display("FAIL bp_stable: out=%h alu=%h/%h/%b want %h %h/%h/%b", s.o, s.aa, s.ab, s.ctl, held.o, held.aa, held.ab, held.ctl);
                end
            end
            if (j >= 4 && j < 7) begin
                e = model(ops[j-4], as[j-4], bs[j-4], 5'(j - 4));
                vectors++;
                if (s.ov !== 1'b1 || s.o !== e) begin
                    miscompares++; $display("FAIL bp_order[%0d]: ov=%b out=%h want 1 %h", j - 4, s.ov, s.o, e);
                end
            end
            if (j == 7) begin
                vectors++;
                if (s.ov !== 1'b0) begin
                    miscompares++; $display("FAIL bp_empty: out_valid=%b want 0", s.ov);
                end
            end
        end
    endtask

    task automatic test_illegal();
        snap_t       s;
        out_t        e;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        e = model(4'd5, a, b, 5'd7);
        cycle(1'b1, 4'd5, a, b, 5'd7, 1'b1, s);
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, s);
        vectors++;
        if (s.ctl !== 2'b00) begin
            miscompares++; $display("FAIL illegal_ctl: alu_ctl=%b want 00", s.ctl);
        end
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, s);
        vectors++;
        if (s.ov !== 1'b1 || s.o.ill !== 1'b1 || s.o.tk !== 1'b0 || s.o.result !== 32'd0 || s.o !== e) begin
            miscompares++; $display("FAIL illegal_out: ov=%b out=%h want 1 %h", s.ov, s.o, e);
        end
    endtask

    task automatic test_reset_midstall();
        snap_t s;
        out_t  e;
        cycle(1'b1, 4'd0, 32'd11, 32'd22, 5'd1, 1'b0, s);
        cycle(1'b1, 4'd1, 32'd33, 32'd44, 5'd2, 1'b0, s);
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL rst_prefill: in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_async_hs: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        vectors++;
        if (out_result !== 32'd0 || out_flags !== 4'd0 || out_tag !== 5'd0 || out_is_branch !== 1'b0 ||
            out_taken !== 1'b0 || out_illegal !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctl !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_async_vals: res=%h flags=%b tag=%h alu=%h/%h/%b want all 0", out_result, out_flags, out_tag, alu_a, alu_b, alu_ctl);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        e = model(4'd2, 32'h1234_5678, 32'h0FF0_0FF0, 5'd9);
        cycle(1'b1, 4'd2, 32'h1234_5678, 32'h0FF0_0FF0, 5'd9, 1'b1, s);
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, s);
        vectors++;
        if (s.ov !== 1'b0) begin
            miscompares++; $display("FAIL rst_latency_early: out_valid=%b want 0", s.ov);
        end
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, s);
        vectors++;
        if (s.ov !== 1'b1 || s.o !== e) begin
            miscompares++; $display("FAIL rst_first_op: ov=%b out=%h want 1 %h", s.ov, s.o, e);
        end
        cycle(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, s);
        vectors++;
        if (s.ov !== 1'b0) begin
            miscompares++; $display("FAIL rst_discard: out_valid=%b want 0", s.ov);
        end
    endtask

    task automatic test_random();
        snap_t       s, prev;
        out_t        q[$];
        out_t        e;
        logic        v, rdy, prev_rdy, have_prev;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [31:0] corner [5];
        logic [4:0]  tag;
        corner = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        have_prev = 1'b0;
        prev = '0;
        prev_rdy = 1'b1;
        for (int n = 0; n < 420; n++) begin
            if (n < 400) begin
                v   = ($urandom_range(0, 3) != 0);
                op  = 4'($urandom_range(0, 15));
                a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
                b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
                if ($urandom_range(0, 7) == 0) b = a;
                tag = 5'($urandom);
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                v = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; tag = 5'd0; rdy = 1'b1;
            end
            cycle(v, op, a, b, tag, rdy, s);
            if (have_prev && prev.ov && !prev_rdy) begin
                vectors++;
                if (s.ov !== 1'b1 || s.o !== prev.o) begin
                    miscompares++; $display("FAIL rand_stall_out[%0d]: out=%h want %h", n, s.o, prev.o);
                end
            end
            if (have_prev && !prev.in_rdy) begin
                vectors++;
                if (s.aa !== prev.aa || s.ab !== prev.ab || s.ctl !== prev.ctl) begin
                    miscompares++;
                    $display("FAIL rand_stall_alu[%0d]: alu=%h/%h/%b want %h/%h/%b", n, s.aa, s.ab, s.ctl, prev.aa, prev.ab, prev.ctl);
                end
            end
            if (s.ov && rdy) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++; $display("FAIL rand_spurious[%0d]: out=%h want no output", n, s.o);
                end else begin
                    e = q.pop_front();
                    if (s.o !== e) begin
                        miscompares++; $display("FAIL rand_out[%0d]: out=%h want %h", n, s.o, e);
                    end
                end
            end
            if (v && s.in_rdy) q.push_back(model(op, a, b, tag));
            prev = s;
            prev_rdy = rdy;
            have_prev = 1'b1;
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++; $display("FAIL rand_drain: %0d ops outstanding want 0", q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_op = 4'd0; in_a = 32'd0; in_b = 32'd0; in_tag = 5'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_branch();
        test_backpressure();
        test_illegal();
        test_reset_midstall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
